// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the up/down stopwatch core.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] ZERO  = 4'd0;
  localparam logic [DIGIT_W-1:0] ONE   = 4'd1;
  localparam logic [DIGIT_W-1:0] TWO   = 4'd2;
  localparam logic [DIGIT_W-1:0] THREE = 4'd3;
  localparam logic [DIGIT_W-1:0] FOUR  = 4'd4;
  localparam logic [DIGIT_W-1:0] FIVE  = 4'd5;
  localparam logic [DIGIT_W-1:0] SIX   = 4'd6;
  localparam logic [DIGIT_W-1:0] SEVEN = 4'd7;
  localparam logic [DIGIT_W-1:0] EIGHT = 4'd8;
  localparam logic [DIGIT_W-1:0] NINE  = 4'd9;

  // Preset nibbles above 9 are not valid BCD; pin them to 9.
  function automatic logic [DIGIT_W-1:0] clamp9(input logic [DIGIT_W-1:0] n);
    return (n > NINE) ? NINE : n;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter: clear, preset load and +/-1 step with
// a carry/borrow flag when the digit wraps.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               step,
  input  logic               up,
  output logic [DIGIT_W-1:0] q,
  output logic               carry_out
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = ZERO;
    end else if (ld) begin
      q_d = ld_val;
    end else if (step) begin
      if (up) begin
        q_d = (q_q == NINE) ? ZERO : q_q + ONE;
      end else begin
        q_d = (q_q == ZERO) ? NINE : q_q - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= ZERO;
    end else begin
      q_q <= q_d;
    end
  end

  // The caller only raises step when no clear/load is pending.
  assign carry_out = step && (up ? (q_q == NINE) : (q_q == ZERO));
  assign q         = q_q;

endmodule

// File: rtl/bcd_updown_timer.sv
// Parametrised BCD up/down stopwatch: prescaled tick, digit chain with
// wrap or saturate at the range ends, preset load and lap-hold display.
module bcd_updown_timer
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DVSR       = 10000000,
  parameter bit WRAP       = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          up,
  input  logic                          clear,
  input  logic                          load,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
  input  logic                          lap,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
  output logic                          tick,
  output logic                          rollover,
  output logic                          overflow,
  output logic                          holding
);

  localparam int                CW         = DIGIT_W * NUM_DIGITS;
  localparam int                PW         = (DVSR > 1) ? $clog2(DVSR) : 1;
  localparam logic [PW-1:0]     PRESC_LAST = PW'(DVSR - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic              overflow_q, overflow_d;
  logic              rollover_q;
  logic              holding_q, holding_d;
  logic [CW-1:0]     snap_q, snap_d;

  logic [CW-1:0]         count;
  logic [NUM_DIGITS-1:0] carry;
  logic [NUM_DIGITS-1:0] dig_step;
  logic                  tick_eff;
  logic                  all9, all0, at_end;
  logic                  step_en, sat_hit;

  // A tick landing on a clear/load (or reset) cycle is discarded outright.
  assign tick_eff = enable && (presc_q == PRESC_LAST) && !reset && !clear && !load;

  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count[i*DIGIT_W +: DIGIT_W] != NINE) all9 = 1'b0;
      if (count[i*DIGIT_W +: DIGIT_W] != ZERO) all0 = 1'b0;
    end
  end

  assign at_end  = up ? all9 : all0;
  assign sat_hit = tick_eff && at_end && !WRAP;
  assign step_en = tick_eff && !(at_end && !WRAP);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign dig_step[gi] = step_en;
      end else begin : g_upper
        assign dig_step[gi] = carry[gi-1];
      end

      bcd_digit u_digit (
        .clk       (clk),
        .reset     (reset),
        .clr       (clear),
        .ld        (load),
        .ld_val    (clamp9(load_value[gi*DIGIT_W +: DIGIT_W])),
        .step      (dig_step[gi]),
        .up        (up),
        .q         (count[gi*DIGIT_W +: DIGIT_W]),
        .carry_out (carry[gi])
      );
    end
  endgenerate

  always_comb begin
    presc_d = presc_q;
    if (clear || load) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end else if (sat_hit) begin
      overflow_d = 1'b1;
    end
  end

  // Snapshot is taken only on entry to hold; clear never touches it.
  always_comb begin
    holding_d = holding_q ^ lap;
    snap_d    = snap_q;
    if (lap && !holding_q) begin
      snap_d = count;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      overflow_q <= 1'b0;
      rollover_q <= 1'b0;
      holding_q  <= 1'b0;
      snap_q     <= '0;
    end else begin
      presc_q    <= presc_d;
      overflow_q <= overflow_d;
      // The top digit only carries out when the whole range wraps.
      rollover_q <= carry[NUM_DIGITS-1];
      holding_q  <= holding_d;
      snap_q     <= snap_d;
    end
  end

  assign digits   = holding_q ? snap_q : count;
  assign tick     = tick_eff;
  assign rollover = rollover_q;
  assign overflow = overflow_q;
  assign holding  = holding_q;

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Randomised and directed check of bcd_updown_timer (wrap and saturate
// instances) against an integer-valued stopwatch model.
module tb_bcd_updown_timer;

  localparam int N    = 4;
  localparam int D    = 4;
  localparam int MAXV = 9999;

  logic        clk = 1'b0;
  logic        reset, enable, up, clear, load, lap;
  logic [15:0] load_value;

  logic [15:0] dig [2];
  logic        tk  [2];
  logic        ro  [2];
  logic        ov  [2];
  logic        hd  [2];

  int n_vec = 0;
  int n_err = 0;

  int m_cnt   [2];
  int m_presc [2];
  int m_snap  [2];
  bit m_ovf   [2];
  bit m_roll  [2];
  bit m_hold  [2];

  always #5 clk = ~clk;

  bcd_updown_timer #(.NUM_DIGITS(N), .DVSR(D), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .lap(lap), .digits(dig[0]),
    .tick(tk[0]), .rollover(ro[0]), .overflow(ov[0]), .holding(hd[0])
  );

  bcd_updown_timer #(.NUM_DIGITS(N), .DVSR(D), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear),
    .load(load), .load_value(load_value), .lap(lap), .digits(dig[1]),
    .tick(tk[1]), .rollover(ro[1]), .overflow(ov[1]), .holding(hd[1])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    for (int i = 0; i < N; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_dec(input logic [15:0] lv);
    int v;
    int nib;
    v = 0;
    for (int i = N - 1; i >= 0; i--) begin
      nib = int'(lv[i*4 +: 4]);
      if (nib > 9) nib = 9;
      v = v * 10 + nib;
    end
    return v;
  endfunction

  task automatic model_step();
    int  old;
    bit  t;
    for (int w = 0; w < 2; w++) begin
      old = m_cnt[w];
      if (reset) begin
        m_cnt[w] = 0; m_presc[w] = 0; m_snap[w] = 0;
        m_ovf[w] = 0; m_roll[w] = 0; m_hold[w] = 0;
      end else begin
        m_roll[w] = 0;
        if (lap) begin
          if (!m_hold[w]) m_snap[w] = old;
          m_hold[w] = !m_hold[w];
        end
        if (clear) begin
          m_cnt[w] = 0; m_presc[w] = 0; m_ovf[w] = 0;
        end else if (load) begin
          m_cnt[w] = load_dec(load_value); m_presc[w] = 0;
        end else if (enable) begin
          t = (m_presc[w] == D - 1);
          m_presc[w] = t ? 0 : m_presc[w] + 1;
          if (t) begin
            if (up) begin
              if (old == MAXV) begin
                if (w == 0) begin m_cnt[w] = 0; m_roll[w] = 1; end
                else m_ovf[w] = 1;
              end else m_cnt[w] = old + 1;
            end else begin
              if (old == 0) begin
                if (w == 0) begin m_cnt[w] = MAXV; m_roll[w] = 1; end
                else m_ovf[w] = 1;
              end else m_cnt[w] = old - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cyc();
    bit exp_tick;
    @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      exp_tick = enable && (m_presc[w] == D - 1) && !reset && !clear && !load;
      chk($sformatf("digits[%0d]", w), 32'(dig[w]),
          32'(to_bcd(m_hold[w] ? m_snap[w] : m_cnt[w])));
      chk($sformatf("tick[%0d]", w), 32'(tk[w]), 32'(exp_tick));
      chk($sformatf("rollover[%0d]", w), 32'(ro[w]), 32'(m_roll[w]));
      chk($sformatf("overflow[%0d]", w), 32'(ov[w]), 32'(m_ovf[w]));
      chk($sformatf("holding[%0d]", w), 32'(hd[w]), 32'(m_hold[w]));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v;
    run(1);
    load = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    run(1);
    clear = 1'b0;
  endtask

  task automatic do_lap();
    lap = 1'b1;
    run(1);
    lap = 1'b0;
  endtask

  initial begin
    for (int w = 0; w < 2; w++) begin
      m_cnt[w] = 0; m_presc[w] = 0; m_snap[w] = 0;
      m_ovf[w] = 0; m_roll[w] = 0; m_hold[w] = 0;
    end
    reset = 1'b1; enable = 1'b1; up = 1'b1; clear = 1'b0;
    load = 1'b0; lap = 1'b0; load_value = 16'h0;
    run(3);
    reset = 1'b0;

    // Free-running count from reset.
    run(40);
    chk("count_10_ticks", 32'(dig[0]), 32'h0010);
    run(360);
    chk("count_100_ticks", 32'(dig[0]), 32'h0100);

    // Range ends: wrap instance rolls over, saturate instance sticks.
    do_load(16'h9999);
    run(4);
    chk("wrap_up_digits", 32'(dig[0]), 32'h0000);
    chk("wrap_up_roll", 32'(ro[0]), 32'h1);
    chk("sat_up_digits", 32'(dig[1]), 32'h9999);
    chk("sat_up_ovf", 32'(ov[1]), 32'h1);
    run(1);
    chk("roll_one_cycle", 32'(ro[0]), 32'h0);
    up = 1'b0;
    do_load(16'h0000);
    run(4);
    chk("wrap_dn_digits", 32'(dig[0]), 32'h9999);
    chk("wrap_dn_roll", 32'(ro[0]), 32'h1);
    chk("sat_dn_digits", 32'(dig[1]), 32'h0000);
    do_clear();
    chk("clear_ovf", 32'(ov[1]), 32'h0);
    up = 1'b1;
    do_load(16'h9998);
    run(12);
    chk("sat_hold_9999", 32'(dig[1]), 32'h9999);
    chk("sat_ovf_set", 32'(ov[1]), 32'h1);
    do_clear();
    chk("clear_digits", 32'(dig[1]), 32'h0000);

    // Enable gap mid-period and direction change mid-period.
    run(2);
    enable = 1'b0;
    run(7);
    enable = 1'b1;
    run(5);
    up = 1'b0;
    run(6);
    up = 1'b1;
    run(6);

    // Load coinciding with a tick, then clear+load together.
    do_load(16'h0000);
    run(3);
    do_load(16'h12F4);
    chk("load_clamp", 32'(dig[0]), 32'h1294);
    clear = 1'b1; load = 1'b1; load_value = 16'h5555;
    run(1);
    clear = 1'b0; load = 1'b0;
    chk("clear_beats_load", 32'(dig[0]), 32'h0000);

    // Lap hold.
    do_load(16'h0042);
    do_lap();
    run(20);
    chk("lap_frozen", 32'(dig[0]), 32'h0042);
    do_lap();
    chk("lap_release", 32'(dig[0]), 32'h0047);
    do_lap();
    run(3);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    chk("reset_hold", 32'(hd[0]), 32'h0);
    chk("reset_digits", 32'(dig[0]), 32'h0000);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      enable     = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) up = ~up;
      clear      = ($urandom_range(0, 59) == 0);
      load       = ($urandom_range(0, 29) == 0);
      lap        = ($urandom_range(0, 39) == 0);
      load_value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_value = 16'h9999 - 16'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) load_value = 16'($urandom_range(0, 1));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_updown_timer.md
# bcd_updown_timer

Parametrised BCD up/down stopwatch core. NUM_DIGITS decimal digits advance once per prescaled tick (DVSR clock cycles), with wrap or saturate at the range ends, synchronous clear and preset load, and a lap-hold display freeze. Sits between the board clock and the seven-segment multiplexer. Drop-in generalisation of the fixed 4-digit, 100 ms stopwatch.

## Interface
- NUM_DIGITS, 4: number of BCD digits, ≥1.
- DVSR, 10000000: clk cycles per count tick, ≥1 (100 ms at 100 MHz).
- WRAP, 1: 1 = wrap at range ends; 0 = saturate and set sticky overflow.
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  prescaler and counting run while high.
- up  in  1  1 = count up, 0 = count down; sampled on tick cycles.
- clear  in  1  synchronous clear of count, prescaler and overflow.
- load  in  1  load load_value into count.
- load_value  in  4*NUM_DIGITS  preset, digit 0 in bits [3:0].
- lap  in  1  single-cycle pulse toggling lap hold.
- digits  out  4*NUM_DIGITS  displayed BCD value, digit 0 LSB nibble.
- tick  out  1  one-cycle pulse on each count step.
- rollover  out  1  one-cycle pulse when the count wraps.
- overflow  out  1  sticky; set on saturation hit (WRAP=0 only).
- holding  out  1  lap hold active.

## Operation
- Reset values: all digits 0, prescaler 0, tick 0, rollover 0, overflow 0, holding 0.
- Prescaler width $clog2(DVSR) (min 1). It counts 0..DVSR-1 while enable=1, wraps to 0, and freezes (no reset) while enable=0.
  - tick = enable && prescaler==DVSR-1. With DVSR=1, tick is high every enabled cycle.
- On tick the count steps ±1 in BCD per up. A digit carries/borrows to the next only when it wraps 9→0 (up) or 0→9 (down).
- Up from all-9s:
  - WRAP=1: result all-0s; rollover pulses.
  - WRAP=0: count holds all-9s; overflow is set.
- Down from all-0s:
  - WRAP=1: result all-9s; rollover pulses.
  - WRAP=0: count holds 0; overflow is set.
- Priority, highest first: reset > clear > load > tick.
  - clear zeroes count, prescaler and overflow. holding is unaffected.
  - load writes load_value. Any nibble >9 is clamped to 9. Prescaler is zeroed; overflow is unchanged.
  - A tick coinciding with clear or load is discarded, and tick/rollover are not asserted.
- Lap hold:
  - A lap pulse toggles holding.
  - On entering hold, digits latch the current count; counting continues internally.
  - On leaving hold, digits track the count again from the next cycle.
  - lap coinciding with clear: clear applies and holding toggles; a held display keeps its snapshot.
  - reset exits hold.
- A change of up mid-period takes effect at the next tick; the prescaler is not restarted.

## Timing
- tick is combinational from registered state; the count updates at the clock edge ending the tick cycle.
- rollover is registered: high for one cycle, coincident with the first cycle the wrapped value is visible.
- overflow is set on the same edge as the saturating tick and stays set until clear or reset.
- digits are registered (count, or snapshot when holding). Latency from the tick edge to new digits is 0 cycles beyond that edge.
- clear/load: the new value is visible the cycle after assertion. The next tick follows DVSR enabled cycles later.
- lap: holding and the snapshot are visible the cycle after the pulse.

## Structure
- Shared package bcd_pkg holds:
  - BCD constants ZERO..NINE;
  - the digit-width constant 4;
  - a clamp-to-9 function for load nibbles.
- Sub-module bcd_digit is one decade cell, instantiated NUM_DIGITS times in a generate chain.
  - Inputs: clk, reset, clr, ld, ld_val, step, up.
  - Outputs: q, carry_out (wrap 9→0 up / 0→9 down when stepped).
  - step of digit i+1 = tick && carry_out of digit i.
- Range detection (all-9s / all-0s) and WRAP/saturate gating live in the top level.

## Test plan
- NUM_DIGITS=4, DVSR=4, up=1, enable=1 from reset: tick every 4th cycle; digits reach 0x0010 after 10 ticks and 0x0100 after 100.
- WRAP=1, load 0x9999, one up tick: digits 0x0000 and rollover high one cycle. Load 0x0000, one down tick: digits 0x9999 and rollover pulses.
- WRAP=0, load 0x9998, up: 0x9999 then stays 0x9999 with overflow=1. clear gives digits 0x0000 and overflow=0.
- enable low for 7 cycles at prescaler=2: no tick; resumes and the tick arrives 1 enabled cycle later. Toggle up mid-period: direction flips at the next tick only.
- load 0x12F4 with a simultaneous tick: digits 0x1294, no tick pulse. clear+load together: digits 0x0000.
- lap at count 0x0042: digits frozen at 0x0042 while 5 ticks pass. Second lap: digits show 0x0047 next cycle. reset during hold: holding=0, digits 0x0000.
